frame_receiver: RTL and testbench
=================================

# frame_receiver

Receive side of the single-wire shared bus that `node` instances drive. The block:

- samples `main_bus` once per `clock`;
- delineates each serial frame (start bit, sender address, receiver address, 64-bit payload, CRC-4, stop bit);
- checks the CRC and filters frames on `nodeAddress`;
- presents accepted payloads on `DataOut` with a one-cycle valid strobe.

It sits between the bus wire and the node's local consumer, and drives `isFree` for the node's transmit arbitration.

## Interface

Parameters:
- `DATA_W`, 64, payload width in bits
- `ADDR_W`, 4, sender/receiver address width
- `CRC_POLY`, 4'h3, CRC-4 generator x^4+x+1 without the x^4 term
- `BROADCAST`, 4'hF, receiver address accepted by every node

Ports:
- `clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `main_bus`  in  1  serial bus line; idles high
- `nodeAddress`  in  ADDR_W  this node's address; static while a frame is in flight
- `isFree`  out  1  high when no frame is in progress on the bus
- `DataOut`  out  DATA_W  payload of the last accepted frame
- `senderAddress`  out  ADDR_W  sender field of the last accepted frame
- `data_valid`  out  1  one-cycle pulse: `DataOut`/`senderAddress` just updated
- `crc_error`  out  1  one-cycle pulse: addressed frame failed CRC
- `frame_error`  out  1  one-cycle pulse: addressed frame had stop bit = 0

## Operation

Frame format, MSB first, one bit per clock:
- start bit 0
- sender[3:0]
- receiver[3:0]
- data[63:0]
- crc[3:0]
- stop bit 1
- Total length: 78 bits (77 + stop).

CRC rules:
- Serial LFSR, init 4'h0, computed over the 72 sender/receiver/data bits.
- Per bit: `fb = crc[3] ^ bit`, then `crc = {crc[2:0],0} ^ (fb ? CRC_POLY : 0)`.

FSM states and transitions:
- IDLE: `main_bus`=0 → HDR, bit counter cleared, LFSR cleared.
- HDR: 8 bits shifted into the address registers and the LFSR → PAYLOAD.
- PAYLOAD: 64 bits into the data shift register and the LFSR → CRCF.
- CRCF: 4 bits into the received-CRC register → STOP.
- STOP: sample the stop bit, evaluate the frame, go to IDLE.

Acceptance rule: the frame is addressed to this node when receiver == `nodeAddress` or receiver == `BROADCAST`. For an addressed frame, the result at STOP is decided in this priority order:
1. stop=0 → `frame_error` (even if CRC also bad).
2. CRC mismatch → `crc_error`.
3. Otherwise → load `DataOut` and `senderAddress`, pulse `data_valid`.

Non-addressed frames are fully tracked, so `isFree` stays correct, but produce no pulse and no output change.

Outputs hold until the next accepted frame. An error never modifies `DataOut` or `senderAddress`.

## Timing

- Reset values: `isFree`=1, `DataOut`=0, `senderAddress`=0, all pulses 0, FSM=IDLE. Reset overrides every other event.
- Reset mid-frame: the frame is abandoned with no pulses, and the block returns to IDLE the next cycle.
- Start-bit sampling edge = edge 0. Stop bit is sampled at edge 77.
- `data_valid` / `crc_error` / `frame_error` are high for the single cycle after edge 77. `DataOut` is valid in that same cycle.
- `isFree` falls after edge 0 and rises after edge 77.
- Back-to-back frames: a 0 sampled at edge 78 is a new start bit. No idle gap is required.
- A 0 on `main_bus` in IDLE always starts a frame. There is no glitch filter.

## Structure

- Package `bus_frame_pkg` holds:
  - `DATA_W`, `ADDR_W`, `CRC_POLY`, `BROADCAST`;
  - `FRAME_BITS`=78;
  - the FSM state enum (IDLE, HDR, PAYLOAD, CRCF, STOP).
  The transmit path shares this package.
- Sub-module `crc4_serial` has ports clear, enable, bit, crc[3:0]. It is reused by the transmitter.
- The FSM, the 7-bit bit counter and the shift registers live in `frame_receiver`.

## Test plan

- **Reset:** hold `reset` 3 cycles with `main_bus`=1 → `isFree`=1, `DataOut`=0, `senderAddress`=0, no pulses.
- **Good frame:** `nodeAddress`=1; send sender=0, receiver=1, data=64'd10, crc=4'h8, stop=1 → one-cycle `data_valid` after edge 77, `DataOut`=10, `senderAddress`=0, `isFree` low for exactly 77 cycles.
- **Bad CRC:** same frame with crc=4'h9 → `crc_error` pulse, `DataOut` unchanged, no `data_valid`.
- **Address filter:** `nodeAddress`=2, same good frame → no pulses, `isFree` still low 77 cycles. Repeat with receiver=4'hF and correct CRC from the reference model → `data_valid`.
- **Framing:** good frame with stop=0 → `frame_error` only.
- **Reset mid-payload and back-to-back:** `reset` at edge 30 → `isFree`=1 next cycle. Then two good frames with no gap → two `data_valid` pulses exactly 78 cycles apart.

Source files
------------

// File: rtl/bus_frame_pkg.sv
// Shared definitions for the serial bus frame: field widths, CRC-4 generator and FSM states.
// Used by both the receive and transmit paths.
package bus_frame_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam logic [3:0] CRC_POLY = 4'h3;
  localparam logic [ADDR_W-1:0] BROADCAST = 4'hF;
  localparam int CRC_W = 4;
  localparam int FRAME_BITS = 78;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CRCF,
    STOP
  } frameState_t;

  // One serial CRC-4 step: shift left, fold in the generator when the feedback is set.
  function automatic logic [3:0] crc4Step(input logic [3:0] crc, input logic b,
                                          input logic [3:0] poly);
    logic fb;
    fb = crc[3] ^ b;
    return {crc[2:0], 1'b0} ^ (fb ? poly : 4'h0);
  endfunction

endpackage

// File: rtl/crc4_serial.sv
// Serial CRC-4 LFSR, one bit per enabled clock; result is registered, visible the cycle after the last bit.
// No backpressure: clear wins over enable.
module crc4_serial
  import bus_frame_pkg::*;
#(
  parameter logic [3:0] POLY = CRC_POLY
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       serialBit,
  output logic [3:0] crc
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      crc <= 4'h0;
    end else if (enable) begin
      crc <= crc4Step(crc, serialBit, POLY);
    end
  end

endmodule

// File: rtl/frame_receiver.sv
// Bus receiver: delineates 78-bit frames, checks CRC-4, filters on address; result pulses the cycle after the stop bit.
// No backpressure: the bus is sampled every clock and results are single-cycle strobes.
module frame_receiver #(
  parameter int DATA_W = bus_frame_pkg::DATA_W,
  parameter int ADDR_W = bus_frame_pkg::ADDR_W,
  parameter logic [3:0] CRC_POLY = bus_frame_pkg::CRC_POLY,
  parameter logic [ADDR_W-1:0] BROADCAST = bus_frame_pkg::BROADCAST
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              main_bus,
  input  logic [ADDR_W-1:0] nodeAddress,
  output logic              isFree,
  output logic [DATA_W-1:0] DataOut,
  output logic [ADDR_W-1:0] senderAddress,
  output logic              data_valid,
  output logic              crc_error,
  output logic              frame_error
);

  import bus_frame_pkg::*;

  localparam int HDR_W = 2 * ADDR_W;

  frameState_t       state;
  logic [6:0]        bitCnt;
  logic [HDR_W-1:0]  hdrShift;
  logic [DATA_W-1:0] dataShift;
  logic [3:0]        rxCrc;
  logic [3:0]        calcCrc;
  logic              crcClear;
  logic              crcEnable;
  logic [ADDR_W-1:0] rxReceiver;
  logic [ADDR_W-1:0] rxSender;
  logic              addressed;

  // LFSR is held clear while idle so it starts from zero on the first header bit.
  assign crcClear  = (state == IDLE);
  assign crcEnable = (state == HDR) || (state == PAYLOAD);

  crc4_serial #(
    .POLY(CRC_POLY)
  ) u_crc (
    .clock    (clock),
    .reset    (reset),
    .clear    (crcClear),
    .enable   (crcEnable),
    .serialBit(main_bus),
    .crc      (calcCrc)
  );

  assign rxSender   = hdrShift[HDR_W-1:ADDR_W];
  assign rxReceiver = hdrShift[ADDR_W-1:0];
  assign addressed  = (rxReceiver == nodeAddress) || (rxReceiver == BROADCAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      bitCnt        <= 7'd0;
      hdrShift      <= '0;
      dataShift     <= '0;
      rxCrc         <= 4'h0;
      isFree        <= 1'b1;
      DataOut       <= '0;
      senderAddress <= '0;
      data_valid    <= 1'b0;
      crc_error     <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      crc_error   <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          bitCnt <= 7'd0;
          if (!main_bus) begin
            state  <= HDR;
            isFree <= 1'b0;
          end
        end
        HDR: begin
          hdrShift <= {hdrShift[HDR_W-2:0], main_bus};
          if (bitCnt == 7'(HDR_W - 1)) begin
            state  <= PAYLOAD;
            bitCnt <= 7'd0;
          end else begin
            bitCnt <= bitCnt + 7'd1;
          end
        end
        PAYLOAD: begin
          dataShift <= {dataShift[DATA_W-2:0], main_bus};
          if (bitCnt == 7'(DATA_W - 1)) begin
            state  <= CRCF;
            bitCnt <= 7'd0;
          end else begin
            bitCnt <= bitCnt + 7'd1;
          end
        end
        CRCF: begin
          rxCrc <= {rxCrc[2:0], main_bus};
          if (bitCnt == 7'(CRC_W - 1)) begin
            state  <= STOP;
            bitCnt <= 7'd0;
          end else begin
            bitCnt <= bitCnt + 7'd1;
          end
        end
        STOP: begin
          state  <= IDLE;
          isFree <= 1'b1;
          // A bad stop bit outranks a CRC mismatch.
          if (addressed) begin
            if (!main_bus) begin
              frame_error <= 1'b1;
            end else if (rxCrc != calcCrc) begin
              crc_error <= 1'b1;
            end else begin
              DataOut       <= dataShift;
              senderAddress <= rxSender;
              data_valid    <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          isFree <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: hand-computed frames, pulse counting and output checks.
module tb_frame_receiver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        main_bus = 1'b1;
  logic [3:0]  nodeAddress = 4'h1;
  logic        isFree;
  logic [63:0] DataOut;
  logic [3:0]  senderAddress;
  logic        data_valid;
  logic        crc_error;
  logic        frame_error;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int dvCount = 0;
  int ceCount = 0;
  int feCount = 0;
  int freeLow = 0;
  int dvCycle = 0;
  int dvPrevCycle = 0;

  frame_receiver dut (
    .clock        (clock),
    .reset        (reset),
    .main_bus     (main_bus),
    .nodeAddress  (nodeAddress),
    .isFree       (isFree),
    .DataOut      (DataOut),
    .senderAddress(senderAddress),
    .data_valid   (data_valid),
    .crc_error    (crc_error),
    .frame_error  (frame_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (data_valid) begin
      dvCount = dvCount + 1;
      dvPrevCycle = dvCycle;
      dvCycle = cyc;
    end
    if (crc_error) ceCount = ceCount + 1;
    if (frame_error) feCount = feCount + 1;
    if (!isFree) freeLow = freeLow + 1;
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearStats();
    dvCount = 0;
    ceCount = 0;
    feCount = 0;
    freeLow = 0;
  endtask

  task automatic sendBit(input logic b);
    main_bus = b;
    @(posedge clock);
    #1;
  endtask

  task automatic sendFrame(input logic [3:0] s, input logic [3:0] r, input logic [63:0] d,
                           input logic [3:0] c, input logic stopBit);
    logic [77:0] f;
    f = {1'b0, s, r, d, c, stopBit};
    for (int i = 77; i >= 0; i--) sendBit(f[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sendBit(1'b1);
  endtask

  initial begin
    // Reset held three cycles with the bus idle.
    main_bus = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkVal("rst_isFree", isFree, 1);
    checkVal("rst_DataOut", DataOut, 0);
    checkVal("rst_sender", senderAddress, 0);
    checkVal("rst_pulses", {data_valid, crc_error, frame_error}, 0);
    reset = 1'b0;
    idle(2);

    // Good frame addressed to node 1.
    nodeAddress = 4'h1;
    clearStats();
    sendFrame(4'h0, 4'h1, 64'd10, 4'h8, 1'b1);
    checkVal("good_dv_after77", data_valid, 1);
    checkVal("good_DataOut", DataOut, 64'd10);
    checkVal("good_sender", senderAddress, 0);
    sendBit(1'b1);
    checkVal("good_dv_single", data_valid, 0);
    idle(3);
    checkVal("good_dvCount", dvCount, 1);
    checkVal("good_errs", ceCount + feCount, 0);
    checkVal("good_freeLow", freeLow, 77);

    // Same frame, wrong CRC.
    clearStats();
    sendFrame(4'h0, 4'h1, 64'd10, 4'h9, 1'b1);
    checkVal("badcrc_pulse", crc_error, 1);
    idle(3);
    checkVal("badcrc_counts", {dvCount[7:0], ceCount[7:0], feCount[7:0]}, 24'h00_01_00);
    checkVal("badcrc_DataOut", DataOut, 64'd10);

    // Good CRC, stop bit low.
    clearStats();
    sendFrame(4'h0, 4'h1, 64'd10, 4'h8, 1'b0);
    checkVal("stop0_pulse", frame_error, 1);
    idle(3);
    checkVal("stop0_counts", {dvCount[7:0], ceCount[7:0], feCount[7:0]}, 24'h00_00_01);

    // Stop bit low and CRC wrong with different payload: framing wins, outputs untouched.
    clearStats();
    sendFrame(4'h5, 4'h1, 64'hFFFF, 4'h9, 1'b0);
    idle(3);
    checkVal("prio_counts", {dvCount[7:0], ceCount[7:0], feCount[7:0]}, 24'h00_00_01);
    checkVal("prio_DataOut", DataOut, 64'd10);
    checkVal("prio_sender", senderAddress, 0);

    // Not addressed to node 2: tracked but silent.
    nodeAddress = 4'h2;
    clearStats();
    sendFrame(4'h0, 4'h1, 64'd10, 4'h8, 1'b1);
    idle(3);
    checkVal("filter_counts", {dvCount[7:0], ceCount[7:0], feCount[7:0]}, 24'h00_00_00);
    checkVal("filter_freeLow", freeLow, 77);

    // Non-addressed frame with a payload that would otherwise show up.
    clearStats();
    sendFrame(4'h7, 4'h3, 64'h1234, 4'h0, 1'b0);
    idle(2);
    checkVal("filter2_counts", {dvCount[7:0], ceCount[7:0], feCount[7:0]}, 24'h00_00_00);
    checkVal("filter2_DataOut", DataOut, 64'd10);

    // Broadcast frame accepted by node 2.
    clearStats();
    sendFrame(4'h0, 4'hF, 64'd10, 4'hB, 1'b1);
    checkVal("bcast_dv", data_valid, 1);
    idle(3);
    checkVal("bcast_dvCount", dvCount, 1);

    // Reset in the middle of the payload.
    nodeAddress = 4'h1;
    clearStats();
    begin
      logic [77:0] f;
      f = {1'b0, 4'h0, 4'h1, 64'd10, 4'h8, 1'b1};
      for (int i = 77; i > 47; i--) sendBit(f[i]);
      checkVal("midrst_busy", isFree, 0);
      reset = 1'b1;
      sendBit(f[47]);
      checkVal("midrst_isFree", isFree, 1);
      checkVal("midrst_DataOut", DataOut, 0);
      reset = 1'b0;
    end
    idle(80);
    checkVal("midrst_counts", {dvCount[7:0], ceCount[7:0], feCount[7:0]}, 24'h00_00_00);

    // Two frames with no idle gap.
    clearStats();
    sendFrame(4'h0, 4'h1, 64'd10, 4'h8, 1'b1);
    sendFrame(4'h3, 4'h1, 64'h8000_0000_0000_0001, 4'hF, 1'b1);
    idle(3);
    checkVal("b2b_dvCount", dvCount, 2);
    checkVal("b2b_spacing", dvCycle - dvPrevCycle, 78);
    checkVal("b2b_DataOut", DataOut, 64'h8000_0000_0000_0001);
    checkVal("b2b_sender", senderAddress, 4'h3);
    checkVal("b2b_errs", ceCount + feCount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
